// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter: widths, requester
// indices and a one-hot helper.
package regfile_port_arbiter_pkg;

  localparam int REGFILE_DATA_W   = 24;
  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_NUM_REGS = 32;
  localparam int REQ_CTRL         = 0;
  localparam int REQ_DBG          = 1;

  typedef enum logic {
    REQ_IDX_CTRL = 1'b0,
    REQ_IDX_DBG  = 1'b1
  } req_idx_e;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: the pointer breaks ties, and the mask can
// exclude a requester entirely (used to hold a lock).
module rr_arbiter_2
  import regfile_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic [1:0] eligible;

  assign eligible = req_i & mask_i;

  // NOTE: gnt_o gets a default before any conditional so every path assigns it and no latch is inferred.
  always_comb begin
    gnt_o = eligible;
    if (&eligible) begin
      gnt_o = idx_to_onehot(ptr_i);
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single-op-per-cycle register file between the control unit and
// the debug port. Optional grant locking is enabled with REGFILE_ARB_LOCK_EN.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = REGFILE_DATA_W,
  parameter int ADDR_W  = REGFILE_ADDR_W,
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_a,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_b,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic                      rf_write_enable,
  output logic                      rf_read_enable,
  output logic [ADDR_W-1:0]         rf_write_reg,
  output logic [ADDR_W-1:0]         rf_read_reg_1,
  output logic [ADDR_W-1:0]         rf_read_reg_2,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic [DATA_W-1:0]         rf_data_reg_1,
  input  logic [DATA_W-1:0]         rf_data_reg_2,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data_1,
  output logic [DATA_W-1:0]         rsp_data_2
);

  logic       rr_ptr_q, rr_ptr_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;
  logic [1:0] lock_mask;
  logic [1:0] gnt;
  logic       transfer;
  logic       gnt_idx;
  logic       sel_we;

`ifdef REGFILE_ARB_LOCK_EN
  logic lock_active_q, lock_active_d;
  logic lock_owner_q, lock_owner_d;

  assign lock_mask = lock_active_q ? idx_to_onehot(lock_owner_q) : 2'b11;

  always_comb begin
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    if (transfer) begin
      lock_active_d = req_lock[gnt_idx];
      lock_owner_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
    end
  end
`else
  logic unused_req_lock;

  assign lock_mask       = 2'b11;
  assign unused_req_lock = ^req_lock;
`endif

  rr_arbiter_2 u_arb (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .mask_i (lock_mask),
    .gnt_o  (gnt)
  );

  assign req_ready = rst_n ? gnt : '0;
  assign transfer  = |req_ready;
  assign gnt_idx   = req_ready[REQ_DBG];
  assign sel_we    = req_we[gnt_idx];

  // Idle cycles leave gnt_idx at 0, so the fields follow the control unit.
  assign rf_write_enable = transfer & sel_we;
  assign rf_read_enable  = transfer & ~sel_we;
  assign rf_write_reg    = gnt_idx ? req_addr_a[ADDR_W +: ADDR_W] : req_addr_a[0 +: ADDR_W];
  assign rf_read_reg_1   = rf_write_reg;
  assign rf_read_reg_2   = gnt_idx ? req_addr_b[ADDR_W +: ADDR_W] : req_addr_b[0 +: ADDR_W];
  assign rf_write_data   = gnt_idx ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];

  always_comb begin
    rsp_valid_d = '0;
    rr_ptr_d    = rr_ptr_q;
    if (rf_read_enable) begin
      rsp_valid_d = idx_to_onehot(gnt_idx);
    end
    if (transfer) begin
      rr_ptr_d = ~gnt_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // A response in flight when reset arrives is suppressed immediately.
  assign rsp_valid  = rst_n ? rsp_valid_q : '0;
  assign rsp_data_1 = rf_data_reg_1;
  assign rsp_data_2 = rf_data_reg_2;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: a register-file model on the
// rf side, a transaction-level reference model, directed cases and random traffic.
module tb_regfile_port_arbiter;

  localparam int DW = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_we = '0;
  logic [1:0]    req_lock = '0;
  logic [2*AW-1:0] req_addr_a = '0;
  logic [2*AW-1:0] req_addr_b = '0;
  logic [2*DW-1:0] req_wdata = '0;

  logic [1:0]    req_ready;
  logic          rf_write_enable, rf_read_enable;
  logic [AW-1:0] rf_write_reg, rf_read_reg_1, rf_read_reg_2;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_data_reg_1 = '0;
  logic [DW-1:0] rf_data_reg_2 = '0;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_data_1, rsp_data_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr_a      (req_addr_a),
    .req_addr_b      (req_addr_b),
    .req_wdata       (req_wdata),
    .req_lock        (req_lock),
    .rf_write_enable (rf_write_enable),
    .rf_read_enable  (rf_read_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_read_reg_1   (rf_read_reg_1),
    .rf_read_reg_2   (rf_read_reg_2),
    .rf_write_data   (rf_write_data),
    .rf_data_reg_1   (rf_data_reg_1),
    .rf_data_reg_2   (rf_data_reg_2),
    .rsp_valid       (rsp_valid),
    .rsp_data_1      (rsp_data_1),
    .rsp_data_2      (rsp_data_2)
  );

  // Register file attached to the rf side: registered reads, one op per cycle.
  logic [DW-1:0] env_mem [32] = '{default: '0};

  always @(posedge clk) begin
    if (rf_write_enable) env_mem[rf_write_reg] <= rf_write_data;
    if (rf_read_enable) begin
      rf_data_reg_1 <= env_mem[rf_read_reg_1];
      rf_data_reg_2 <= env_mem[rf_read_reg_2];
    end
  end

  // Reference model: architectural register contents and arbitration state.
  logic [DW-1:0] m_mem [32] = '{default: '0};
  int            m_ptr = 0;
  bit            m_lock_act = 1'b0;
  int            m_lock_own = 0;
  logic [1:0]    m_rsp = '0;
  logic [DW-1:0] m_d1 = '0;
  logic [DW-1:0] m_d2 = '0;
  int            m_last_g = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] fa(input int i);
    return req_addr_a[i*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] fb(input int i);
    return req_addr_b[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] fw(input int i);
    return req_wdata[i*DW +: DW];
  endfunction

  // Which requester the rules say is served this cycle (-1 for none).
  function automatic int model_grant();
    logic [1:0] v;
    if (rst_n !== 1'b1) return -1;
    v = req_valid;
`ifdef REGFILE_ARB_LOCK_EN
    if (m_lock_act) v = v & ((m_lock_own == 1) ? 2'b10 : 2'b01);
`endif
    if (v == 2'b11) return m_ptr;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  task automatic compare();
    int g;
    int s;
    logic [1:0] er;
    logic [1:0] ersp;
    g    = model_grant();
    s    = (g < 0) ? 0 : g;
    er   = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
    ersp = (rst_n === 1'b1) ? m_rsp : 2'b00;
    check("req_ready", 64'(req_ready), 64'(er));
    check("rf_write_enable", 64'(rf_write_enable), 64'((g >= 0) && req_we[s]));
    check("rf_read_enable", 64'(rf_read_enable), 64'((g >= 0) && !req_we[s]));
    check("rf_write_reg", 64'(rf_write_reg), 64'(fa(s)));
    check("rf_read_reg_1", 64'(rf_read_reg_1), 64'(fa(s)));
    check("rf_read_reg_2", 64'(rf_read_reg_2), 64'(fb(s)));
    check("rf_write_data", 64'(rf_write_data), 64'(fw(s)));
    check("rsp_valid", 64'(rsp_valid), 64'(ersp));
    if (ersp != 2'b00) begin
      check("rsp_data_1", 64'(rsp_data_1), 64'(m_d1));
      check("rsp_data_2", 64'(rsp_data_2), 64'(m_d2));
    end
  endtask

  task automatic model_update();
    int g;
    g = model_grant();
    m_last_g = g;
    m_rsp = 2'b00;
    if (rst_n !== 1'b1) begin
      m_ptr = 0;
      m_lock_act = 1'b0;
      return;
    end
    if (g >= 0) begin
      if (req_we[g]) begin
        m_mem[fa(g)] = fw(g);
      end else begin
        m_rsp = (g == 1) ? 2'b10 : 2'b01;
        m_d1  = m_mem[fa(g)];
        m_d2  = m_mem[fb(g)];
      end
      m_ptr = 1 - g;
      m_lock_act = req_lock[g];
      m_lock_own = g;
    end
  endtask

  task automatic apply(input logic rn, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] lk,
                       input logic [AW-1:0] a0, input logic [AW-1:0] b0, input logic [DW-1:0] w0,
                       input logic [AW-1:0] a1, input logic [AW-1:0] b1, input logic [DW-1:0] w1);
    @(negedge clk);
    rst_n      = rn;
    req_valid  = v;
    req_we     = we;
    req_lock   = lk;
    req_addr_a = {a1, a0};
    req_addr_b = {b1, b0};
    req_wdata  = {w1, w0};
    #1 compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [1:0]    r_v, r_we, r_lk, hold;
  logic [AW-1:0] r_a [2];
  logic [AW-1:0] r_b [2];
  logic [DW-1:0] r_w [2];
  logic          r_rn;

  initial begin
    // Reset: no ready, no enables, no response.
    apply(1'b0, 2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 24'h0, 5'd3, 5'd4, 24'h0);
    tick();
    apply(1'b0, 2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 24'h0, 5'd3, 5'd4, 24'h0);
    tick();
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);

    // Debug port writes r5, then the control unit reads it back.
    apply(1'b1, 2'b10, 2'b10, 2'b00, 5'd0, 5'd0, 24'h0, 5'd5, 5'd0, 24'hABCDEF);
    check("wr5_ready", 64'(req_ready), 64'h2);
    tick();
    apply(1'b1, 2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 24'h0, 5'd0, 5'd0, 24'h0);
    tick();
    check("rd5_rsp_valid", 64'(rsp_valid), 64'h1);
    check("rd5_rsp_data_1", 64'(rsp_data_1), 64'hABCDEF);
    check("rd5_rsp_data_2", 64'(rsp_data_2), 64'h0);

    // Both read continuously: grants alternate starting from requester 1.
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 2'b11, 2'b00, 2'b00, 5'd5, 5'd1, 24'h0, 5'd5, 5'd2, 24'h0);
      check("alt_ready", 64'(req_ready), (k % 2 == 0) ? 64'h2 : 64'h1);
      tick();
      check("alt_rsp_valid", 64'(rsp_valid), (k % 2 == 0) ? 64'h2 : 64'h1);
    end

    // Read/write collision on r7 with the pointer at 0: read sees old value.
    apply(1'b1, 2'b10, 2'b10, 2'b00, 5'd0, 5'd0, 24'h0, 5'd7, 5'd0, 24'h000011);
    tick();
    apply(1'b1, 2'b11, 2'b10, 2'b00, 5'd7, 5'd5, 24'h0, 5'd7, 5'd0, 24'h000022);
    check("coll0_ready", 64'(req_ready), 64'h1);
    tick();
    check("coll0_rsp_data_1", 64'(rsp_data_1), 64'h000011);
    apply(1'b1, 2'b10, 2'b10, 2'b00, 5'd7, 5'd5, 24'h0, 5'd7, 5'd0, 24'h000022);
    tick();

    // Same collision with the pointer at 1: read sees the new value.
    apply(1'b1, 2'b01, 2'b01, 2'b00, 5'd7, 5'd0, 24'h000011, 5'd0, 5'd0, 24'h0);
    tick();
    apply(1'b1, 2'b11, 2'b10, 2'b00, 5'd7, 5'd5, 24'h0, 5'd7, 5'd0, 24'h000022);
    check("coll1_ready", 64'(req_ready), 64'h2);
    tick();
    apply(1'b1, 2'b01, 2'b00, 2'b00, 5'd7, 5'd5, 24'h0, 5'd0, 5'd0, 24'h0);
    tick();
    check("coll1_rsp_data_1", 64'(rsp_data_1), 64'h000022);

    // Reset the cycle after a read grant: the response never appears.
    apply(1'b1, 2'b01, 2'b00, 2'b00, 5'd5, 5'd7, 24'h0, 5'd0, 5'd0, 24'h0);
    tick();
    apply(1'b0, 2'b11, 2'b00, 2'b00, 5'd5, 5'd7, 24'h0, 5'd1, 5'd1, 24'h0);
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rstmid_ready", 64'(req_ready), 64'h0);
    tick();
    apply(1'b1, 2'b11, 2'b00, 2'b00, 5'd5, 5'd7, 24'h0, 5'd1, 5'd1, 24'h0);
    check("rstpost_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rstpost_ptr0_ready", 64'(req_ready), 64'h1);
    tick();

`ifdef REGFILE_ARB_LOCK_EN
    apply(1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 24'h0, 5'd0, 5'd0, 24'h0);
    tick();
    apply(1'b1, 2'b11, 2'b00, 2'b01, 5'd3, 5'd3, 24'h0, 5'd9, 5'd9, 24'h0);
    check("lock_rd_ready", 64'(req_ready), 64'h1);
    tick();
    apply(1'b1, 2'b11, 2'b01, 2'b00, 5'd3, 5'd3, 24'h123456, 5'd9, 5'd9, 24'h0);
    check("lock_wr_ready", 64'(req_ready), 64'h1);
    tick();
    apply(1'b1, 2'b10, 2'b00, 2'b00, 5'd3, 5'd3, 24'h0, 5'd9, 5'd9, 24'h0);
    check("unlock_ready", 64'(req_ready), 64'h2);
    tick();
`endif

    // Single requester toggling: ready follows valid in the same cycle.
    for (int k = 0; k < 8; k++) begin
      r_v = (k % 2 == 1) ? ((k < 4) ? 2'b10 : 2'b01) : 2'b00;
      apply(1'b1, r_v, 2'(k % 3 == 0 ? 3 : 0), 2'b00, 5'(k), 5'(k + 1), 24'(k * 7),
            5'(k + 2), 5'(k + 3), 24'(k * 9));
      check("toggle_ready", 64'(req_ready), 64'(r_v));
      check("toggle_en", 64'(rf_write_enable | rf_read_enable), 64'(r_v != 2'b00));
      tick();
    end

    // Random traffic; a stalled requester holds its request unchanged.
    hold = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      r_rn = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          r_v[i]  = ($urandom_range(0, 3) != 0);
          r_we[i] = $urandom_range(0, 1) == 1;
          r_lk[i] = ($urandom_range(0, 3) == 0);
          r_a[i]  = 5'($urandom_range(0, 7));
          r_b[i]  = 5'($urandom_range(0, 7));
          r_w[i]  = 24'($urandom);
        end
      end
      apply(r_rn, r_v, r_we, r_lk, r_a[0], r_b[0], r_w[0], r_a[1], r_b[1], r_w[1]);
      tick();
      for (int i = 0; i < 2; i++) begin
        hold[i] = r_rn && r_v[i] && (m_last_g != i);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
